// File: rtl/cache_pkg.sv
// Shared constants, types and helpers for the 2-way, 8-set, 32-byte-line L1 data cache.
package cache_pkg;

    localparam int S_INDEX    = 3;
    localparam int S_OFFSET   = 5;
    localparam int NUM_SETS   = 1 << S_INDEX;
    localparam int NUM_WAYS   = 2;
    localparam int TAG_W      = 32 - S_INDEX - S_OFFSET;
    localparam int LINE_W     = 256;
    localparam int LINE_BYTES = LINE_W / 8;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        ST_COMPARE,
        ST_WRITEBACK,
        ST_FILL,
        ST_REFILL
    } state_e;

    // Places a 4-bit word byte-enable at its byte lanes within a line.
    function automatic logic [LINE_BYTES-1:0] line_byte_mask(input logic [2:0] word,
                                                             input logic [3:0] wmask);
        logic [LINE_BYTES-1:0] m;
        m = {{(LINE_BYTES-4){1'b0}}, wmask};
        return m << {word, 2'b00};
    endfunction

    function automatic logic [31:0] line_word(input line_t line, input logic [2:0] word);
        return line[{word, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/cache_array.sv
// Flop-based synchronous-read array with per-lane write enables; a write and a read of the
// same entry on one edge return the newly written lanes (write-first).
module cache_array #(
    parameter int WIDTH      = 8,
    parameter int LANE       = 8,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DEPTH_LOG2-1:0]   raddr,
    input  logic [DEPTH_LOG2-1:0]   waddr,
    input  logic [WIDTH/LANE-1:0]   we,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata
);

    localparam int LANES = WIDTH / LANE;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        mem_d = mem_q;
        for (int l = 0; l < LANES; l++) begin
            if (we[l]) begin
                mem_d[waddr][l*LANE +: LANE] = wdata[l*LANE +: LANE];
            end
        end
        rdata_d = mem_d[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/l1_data_cache.sv
// Pipelined write-back, write-allocate 2-way L1 data cache: stage A captures the CPU request
// while the arrays are read, stage B compares tags, responds, or runs the miss FSM.
module l1_data_cache
    import cache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  cpu_addr,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [3:0]   cpu_wmask,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_resp,
    output logic [31:0]  mem_addr,
    output logic         mem_read,
    output logic         mem_write,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    logic [31:2]          prev_addr_q, prev_addr_d;
    logic                 prev_read_q, prev_read_d;
    logic                 prev_write_q, prev_write_d;
    logic [3:0]           prev_wmask_q, prev_wmask_d;
    logic [31:0]          prev_wdata_q, prev_wdata_d;
    state_e               state_q, state_d;
    logic [NUM_SETS-1:0]  lru_q, lru_d;
    logic [31:0]          rdata_q, rdata_d;

    logic                 stall;
    logic [S_INDEX-1:0]   idx_b, rd_idx;
    logic [TAG_W-1:0]     tag_b;
    logic [2:0]           word_b;

    line_t                data_r [NUM_WAYS];
    logic [TAG_W-1:0]     tag_r  [NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_r, dirty_r;
    logic [LINE_BYTES-1:0] data_we [NUM_WAYS];
    logic [NUM_WAYS-1:0]  tag_we, valid_we, dirty_we;
    line_t                data_wdata;
    logic                 dirty_wdata;

    logic [NUM_WAYS-1:0]  hit_w;
    logic                 hit, hit_way, victim, req_b;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];
    assign idx_b  = prev_addr_q[7:5];
    assign tag_b  = prev_addr_q[31:8];
    assign word_b = prev_addr_q[4:2];
    assign req_b  = prev_read_q | prev_write_q;
    // While stalled the arrays keep re-reading the stage-B set so fills become visible.
    assign rd_idx = stall ? idx_b : cpu_addr[7:5];

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        cache_array #(.WIDTH(LINE_W), .LANE(8), .DEPTH_LOG2(S_INDEX)) u_data (
            .clk(clk), .rst(rst), .raddr(rd_idx), .waddr(idx_b),
            .we(data_we[w]), .wdata(data_wdata), .rdata(data_r[w])
        );
        cache_array #(.WIDTH(TAG_W), .LANE(TAG_W), .DEPTH_LOG2(S_INDEX)) u_tag (
            .clk(clk), .rst(rst), .raddr(rd_idx), .waddr(idx_b),
            .we(tag_we[w]), .wdata(tag_b), .rdata(tag_r[w])
        );
        cache_array #(.WIDTH(1), .LANE(1), .DEPTH_LOG2(S_INDEX)) u_valid (
            .clk(clk), .rst(rst), .raddr(rd_idx), .waddr(idx_b),
            .we(valid_we[w]), .wdata(1'b1), .rdata(valid_r[w])
        );
        cache_array #(.WIDTH(1), .LANE(1), .DEPTH_LOG2(S_INDEX)) u_dirty (
            .clk(clk), .rst(rst), .raddr(rd_idx), .waddr(idx_b),
            .we(dirty_we[w]), .wdata(dirty_wdata), .rdata(dirty_r[w])
        );
    end

    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_w[w] = valid_r[w] && (tag_r[w] == tag_b);
        end
        hit     = |hit_w;
        hit_way = hit_w[1];
        if (!valid_r[0]) begin
            victim = 1'b0;
        end else if (!valid_r[1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[idx_b];
        end
    end

    always_comb begin
        state_d     = state_q;
        lru_d       = lru_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        cpu_resp    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        data_we     = '{default: '0};
        tag_we      = '0;
        valid_we    = '0;
        dirty_we    = '0;
        data_wdata  = {8{prev_wdata_q}};
        dirty_wdata = 1'b1;
        unique case (state_q)
            ST_COMPARE: begin
                if (req_b && hit) begin
                    cpu_resp     = 1'b1;
                    lru_d[idx_b] = ~hit_way;
                    if (prev_read_q) begin
                        rdata_d = line_word(data_r[hit_way], word_b);
                    end
                    if (prev_write_q) begin
                        data_we[hit_way]  = line_byte_mask(word_b, prev_wmask_q);
                        dirty_we[hit_way] = 1'b1;
                    end
                end else if (req_b) begin
                    stall   = 1'b1;
                    state_d = (valid_r[victim] && dirty_r[victim]) ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                stall     = 1'b1;
                mem_write = 1'b1;
                mem_addr  = {tag_r[victim], idx_b, 5'b00000};
                mem_wdata = data_r[victim];
                if (mem_resp) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                mem_addr = {prev_addr_q[31:5], 5'b00000};
                if (mem_resp) begin
                    data_we[victim]  = '1;
                    data_wdata       = mem_rdata;
                    tag_we[victim]   = 1'b1;
                    valid_we[victim] = 1'b1;
                    dirty_we[victim] = 1'b1;
                    dirty_wdata      = 1'b0;
                    state_d          = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall   = 1'b1;
                state_d = ST_COMPARE;
            end
            default: state_d = ST_COMPARE;
        endcase
    end

    always_comb begin
        prev_addr_d  = prev_addr_q;
        prev_read_d  = prev_read_q;
        prev_write_d = prev_write_q;
        prev_wmask_d = prev_wmask_q;
        prev_wdata_d = prev_wdata_q;
        if (!stall) begin
            prev_addr_d  = cpu_addr[31:2];
            prev_read_d  = cpu_read;
            prev_write_d = cpu_write;
            prev_wmask_d = cpu_wmask;
            prev_wdata_d = cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_addr_q  <= '0;
            prev_read_q  <= 1'b0;
            prev_write_q <= 1'b0;
            prev_wmask_q <= '0;
            prev_wdata_q <= '0;
            state_q      <= ST_COMPARE;
            lru_q        <= '0;
            rdata_q      <= '0;
        end else begin
            prev_addr_q  <= prev_addr_d;
            prev_read_q  <= prev_read_d;
            prev_write_q <= prev_write_d;
            prev_wmask_q <= prev_wmask_d;
            prev_wdata_q <= prev_wdata_d;
            state_q      <= state_d;
            lru_q        <= lru_d;
            rdata_q      <= rdata_d;
        end
    end

    // Read data is held between accepted reads.
    assign cpu_rdata = rdata_d;

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed bench for l1_data_cache: a line-granular memory model behind the arbiter port,
// a driver that issues CPU requests, and a monitor that scores every cpu_resp.
module tb_l1_data_cache;

    localparam int MEM_LAT   = 2;
    localparam int MEM_WORDS = 1024;
    localparam int LAT_HIT   = 1;
    localparam int LAT_CLEAN = 6;
    localparam int LAT_DIRTY = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr;
    logic         cpu_read;
    logic         cpu_write;
    logic [3:0]   cpu_wmask;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_resp;
    logic [31:0]  mem_addr;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    logic [31:0]  mem_img [MEM_WORDS];
    logic [64:0]  exp_q [$];
    logic [32:0]  mem_log [$];
    int           tests_run = 0;
    int           tests_failed = 0;
    int           overlap_cnt = 0;
    int           drop_err_cnt = 0;

    l1_data_cache dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_wmask(cpu_wmask), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // memory model: serves one line MEM_LAT negedges after a request is seen
    initial begin
        int lat_cnt;
        logic [9:0] base;
        logic served_rd, served_wr;
        lat_cnt = 0;
        served_rd = 1'b0;
        served_wr = 1'b0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_resp = 1'b0;
            if ((served_rd && mem_read) || (served_wr && mem_write)) drop_err_cnt++;
            served_rd = 1'b0;
            served_wr = 1'b0;
            if (mem_read && mem_write) overlap_cnt++;
            if (rst) begin
                lat_cnt = 0;
            end else if (mem_read || mem_write) begin
                if (lat_cnt == MEM_LAT) begin
                    lat_cnt = 0;
                    mem_resp = 1'b1;
                    base = mem_addr[11:2];
                    if (mem_write) begin
                        for (int k = 0; k < 8; k++) mem_img[int'(base) + k] = mem_wdata[k*32 +: 32];
                        mem_log.push_back({1'b1, mem_addr});
                        served_wr = 1'b1;
                    end else begin
                        for (int k = 0; k < 8; k++) mem_rdata[k*32 +: 32] = mem_img[int'(base) + k];
                        mem_log.push_back({1'b0, mem_addr});
                        served_rd = 1'b1;
                    end
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // monitor: pops one expectation per cpu_resp
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (cpu_resp) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_resp: got resp=1 rdata=0x%08h, expected no response", cpu_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e[64]) check($sformatf("rdata@%08h", e[63:32]), cpu_rdata, e[31:0]);
                end
            end
        end
    end

    // driver tasks: called at a negedge, return at the negedge where cpu_resp is seen
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [3:0] mask,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input int exp_lat, input string name);
        int lat;
        cpu_addr  = addr;
        cpu_read  = !wr;
        cpu_write = wr;
        cpu_wmask = mask;
        cpu_wdata = wdata;
        exp_q.push_back({!wr, addr, exp_rdata});
        lat = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_resp && lat < 60);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_rdata,
                      input int exp_lat, input string name);
        issue(addr, 1'b0, 4'b0000, 32'h0, exp_rdata, exp_lat, name);
    endtask

    task automatic idle(input int n);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < MEM_WORDS; i++) mem_img[i] = 32'hC000_0000 | (i << 2);
        mem_img[32'h60 >> 2]  = 32'h0200_0063;
        mem_img[32'h70 >> 2]  = 32'h0000_0013;
        mem_img[32'h264 >> 2] = 32'h2654_2023;

        rst = 1'b1;
        cpu_addr = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_wmask = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        check("reset_resp", cpu_resp, 0);
        check("reset_rdata", cpu_rdata, 0);
        check("reset_mem_read", mem_read, 0);
        check("reset_mem_write", mem_write, 0);
        rst = 1'b0;
        @(negedge clk);

        rd(32'h60, 32'h0200_0063, LAT_CLEAN, "cold_0x60");
        rd(32'h60, 32'h0200_0063, LAT_HIT, "hold1_0x60");
        rd(32'h60, 32'h0200_0063, LAT_HIT, "hold2_0x60");
        rd(32'h7c, 32'hC000_007C, LAT_HIT, "hit_0x7c");
        rd(32'h70, 32'h0000_0013, LAT_HIT, "hit_0x70");
        idle(3);
        check("rdata_hold_idle", cpu_rdata, 32'h0000_0013);

        rd(32'h264, 32'h2654_2023, LAT_CLEAN, "miss_0x264");
        rd(32'h60, 32'h0200_0063, LAT_HIT, "rehit_0x60");
        rd(32'h464, 32'hC000_0464, LAT_CLEAN, "evict_lru_0x464");
        rd(32'h60, 32'h0200_0063, LAT_HIT, "kept_0x60");
        rd(32'h264, 32'h2654_2023, LAT_CLEAN, "remiss_0x264");

        issue(32'h60, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, LAT_HIT, "write_0x60");
        rd(32'h60, 32'h0200_BEEF, LAT_HIT, "bypass_0x60");
        idle(1);

        rd(32'h464, 32'hC000_0464, LAT_CLEAN, "evict_clean_0x264");
        mem_log.delete();
        rd(32'h864, 32'hC000_0864, LAT_DIRTY, "evict_dirty_0x60");
        check("mem_log_len", mem_log.size(), 2);
        if (mem_log.size() >= 2) begin
            check("wb_is_write_first", {31'b0, mem_log[0][32]}, 1);
            check("wb_addr", mem_log[0][31:0], 32'h60);
            check("fill_after_wb", {31'b0, mem_log[1][32]}, 0);
            check("fill_addr", mem_log[1][31:0], 32'h860);
        end
        check("wb_word0", mem_img[32'h60 >> 2], 32'h0200_BEEF);
        check("wb_word1", mem_img[32'h64 >> 2], 32'hC000_0064);

        // reset while a fill is outstanding
        cpu_addr = 32'h60; cpu_read = 1'b1; cpu_write = 1'b0;
        @(posedge clk);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_read && waited < 20);
        check("fill_started", mem_read, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_cpu_resp", cpu_resp, 0);
        cpu_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        rd(32'h60, 32'h0200_BEEF, LAT_CLEAN, "post_reset_0x60");
        idle(3);

        check("exp_q_drained", exp_q.size(), 0);
        check("mem_rd_wr_overlap", overlap_cnt, 0);
        check("mem_req_drop", drop_err_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
